avalon_st_symbol_pack_adapter: RTL

Parametrised Avalon-ST data format adapter that widens a narrow packet stream by packing RATIO consecutive input beats into one output beat, with correct start/end-of-packet and empty-symbol generation. It sits between a narrow streaming source, such as a byte-wide capture front end, and a wide sink, such as a 24-bit pixel/DMA stream. It replaces the pass-through format adapter wherever source and sink symbol counts differ.

---
 rtl/avalon_st_symbol_pack_adapter_if.sv | 56 +++++
 rtl/avalon_st_symbol_pack_adapter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/avalon_st_symbol_pack_adapter_if.sv
// -----------------------------------------------------------------------------
// avalon_st_symbol_pack_adapter_if
//   Bundles the narrow input stream and the wide output stream of the
//   symbol pack adapter.
//
//   Parameters: SYMBOL_WIDTH, IN_SYMBOLS, RATIO. These must match the values
//   given to the adapter instance that uses this interface.
//
//   Input stream : in_valid, in_ready, in_data, in_startofpacket,
//                  in_endofpacket, in_empty
//   Output stream: out_valid, out_ready, out_data, out_startofpacket,
//                  out_endofpacket, out_empty
//
//   Modports:
//     master - environment side (drives in_*, out_ready)
//     slave  - adapter side (drives in_ready, out_* except out_ready)
// -----------------------------------------------------------------------------
interface avalon_st_symbol_pack_adapter_if #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int IN_SYMBOLS   = 1,
   parameter int RATIO        = 3
);
   localparam int OUT_SYMBOLS = IN_SYMBOLS * RATIO;
   localparam int IN_W        = SYMBOL_WIDTH * IN_SYMBOLS;
   localparam int OUT_W       = SYMBOL_WIDTH * OUT_SYMBOLS;
   localparam int IN_EMPTY_W  = (IN_SYMBOLS > 1) ? $clog2(IN_SYMBOLS) : 1;
   localparam int OUT_EMPTY_W = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [IN_W-1:0]        in_data;
   logic                   in_startofpacket;
   logic                   in_endofpacket;
   logic [IN_EMPTY_W-1:0]  in_empty;

   logic                   out_valid;
   logic                   out_ready;
   logic [OUT_W-1:0]       out_data;
   logic                   out_startofpacket;
   logic                   out_endofpacket;
   logic [OUT_EMPTY_W-1:0] out_empty;

   modport master (
      output in_valid, in_data, in_startofpacket, in_endofpacket, in_empty,
      output out_ready,
      input  in_ready,
      input  out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
   );

   modport slave (
      input  in_valid, in_data, in_startofpacket, in_endofpacket, in_empty,
      input  out_ready,
      output in_ready,
      output out_valid, out_data, out_startofpacket, out_endofpacket, out_empty
   );
endinterface

// File: rtl/avalon_st_symbol_pack_adapter.sv
// -----------------------------------------------------------------------------
// avalon_st_symbol_pack_adapter
//   Avalon-ST data format adapter that widens a packet stream by packing RATIO
//   consecutive input beats into one output beat. Lane 0 (first beat of a
//   group) lands in the most significant bits of out_data. A group closes when
//   RATIO beats have been collected or an end-of-packet beat arrives; out_empty
//   then reports the unused low symbols of the wide beat.
//
//   Ports:
//     clk    - clock, all logic on the rising edge
//     reset  - asynchronous, active-high reset
//     st     - stream interface (slave modport): in_* narrow sink side,
//              out_* wide source side; in_ready = !out_valid || out_ready
//     out_error (only with ST_PACK_PKT_CHECK_EN defined) - registered flag,
//              high on an output beat containing a packet-framing violation
//
//   Build option: define ST_PACK_PKT_CHECK_EN to add out_error and the
//   in-packet tracker. Without it the adapter packs without any checking.
// -----------------------------------------------------------------------------
module avalon_st_symbol_pack_adapter #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int IN_SYMBOLS   = 1,
   parameter int RATIO        = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   avalon_st_symbol_pack_adapter_if.slave   st
`ifdef ST_PACK_PKT_CHECK_EN
   ,
   output logic                             out_error
`endif
);

   localparam int OUT_SYMBOLS = IN_SYMBOLS * RATIO;
   localparam int IN_W        = SYMBOL_WIDTH * IN_SYMBOLS;
   localparam int OUT_W       = SYMBOL_WIDTH * OUT_SYMBOLS;
   localparam int OUT_EMPTY_W = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1;
   localparam int CNT_W       = $clog2(RATIO);

   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [OUT_W-1:0]       out_data_q,  out_data_d;
   logic                   out_sop_q,   out_sop_d;
   logic                   out_eop_q,   out_eop_d;
   logic [OUT_EMPTY_W-1:0] out_empty_q, out_empty_d;

   logic accept;
   logic close;
   logic in_ready_c;

`ifdef ST_PACK_PKT_CHECK_EN
   logic in_pkt_q,    in_pkt_d;
   logic err_acc_q,   err_acc_d;
   logic out_error_q, out_error_d;
   logic viol;
   logic err_group;
`endif

   // Zero-bubble: a held output beat blocks input only while the sink stalls.
   assign in_ready_c = !out_valid_q || st.out_ready;
   assign accept     = st.in_valid && in_ready_c;
   assign close      = accept && ((cnt_q == CNT_W'(RATIO - 1)) || st.in_endofpacket);

   // out_data doubles as the accumulator: a new group can only start when the
   // previous output beat is absent or being consumed this cycle.
   always_comb begin
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_empty_d = out_empty_q;

      if (accept) begin
         if (cnt_q == '0) begin
            out_data_d = '0;
            out_sop_d  = st.in_startofpacket;
         end
         for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_W'(k)) begin
               out_data_d[OUT_W - 1 - k * IN_W -: IN_W] = st.in_data;
            end
         end

         if (close) begin
            out_valid_d = 1'b1;
            out_eop_d   = st.in_endofpacket;
            cnt_d       = '0;
            if (st.in_endofpacket) begin
               out_empty_d = OUT_EMPTY_W'((RATIO - 1 - int'(cnt_q)) * IN_SYMBOLS
                                          + int'(st.in_empty));
            end else begin
               out_empty_d = '0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (!close && out_valid_q && st.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ST_PACK_PKT_CHECK_EN
   // Framing check: sop inside a packet, or a non-sop beat outside one.
   always_comb begin
      in_pkt_d    = in_pkt_q;
      err_acc_d   = err_acc_q;
      out_error_d = out_error_q;
      viol        = 1'b0;
      err_group   = 1'b0;

      if (accept) begin
         viol      = st.in_startofpacket ? in_pkt_q : !in_pkt_q;
         in_pkt_d  = !st.in_endofpacket;
         err_group = ((cnt_q == '0) ? 1'b0 : err_acc_q) | viol;
         if (close) begin
            out_error_d = err_group;
            err_acc_d   = 1'b0;
         end else begin
            err_acc_d   = err_group;
         end
      end

      if (!close && out_valid_q && st.out_ready) begin
         out_error_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_pkt_q    <= 1'b0;
         err_acc_q   <= 1'b0;
         out_error_q <= 1'b0;
      end else begin
         in_pkt_q    <= in_pkt_d;
         err_acc_q   <= err_acc_d;
         out_error_q <= out_error_d;
      end
   end

   assign out_error = out_error_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_empty_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_empty_q <= out_empty_d;
      end
   end

   assign st.in_ready          = in_ready_c;
   assign st.out_valid         = out_valid_q;
   assign st.out_data          = out_data_q;
   assign st.out_startofpacket = out_sop_q;
   assign st.out_endofpacket   = out_eop_q;
   assign st.out_empty         = out_empty_q;

endmodule
